// File: rtl/pfa_issue_ctrl.sv
// Issue/capture stage around the 32-bit combinational adder: operand handshake, settle timer,
// registered sum with carry/overflow, and a running accumulator. Optional macro PFA_SAT_EN saturates on overflow.
module pfa_issue_ctrl #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_acc,
  input  logic             acc_clr,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             busy
);

  if (WIDTH != 32) begin : g_bad_width
    $error("pfa_issue_ctrl: WIDTH must be 32");
  end
  if (SETTLE_CYC < 1 || SETTLE_CYC > 15) begin : g_bad_settle
    $error("pfa_issue_ctrl: SETTLE_CYC must be 1..15");
  end

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  state_t           state, state_n;
  logic [3:0]       cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] eff_acc;
  logic             capture, sample;
  logic             cout, ovf;
  logic [WIDTH-1:0] result;

  assign eff_acc = acc_clr ? '0 : acc;

  assign cout = (add_a[WIDTH-1] & add_b[WIDTH-1]) |
                ((add_a[WIDTH-1] | add_b[WIDTH-1]) & ~add_sum[WIDTH-1]);
  assign ovf  = (add_a[WIDTH-1] == add_b[WIDTH-1]) & (add_sum[WIDTH-1] != add_a[WIDTH-1]);

`ifdef PFA_SAT_EN
  assign result = !ovf            ? add_sum :
                  add_a[WIDTH-1]  ? {1'b1, {(WIDTH-1){1'b0}}} :
                                    {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign result = add_sum;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    capture  = 1'b0;
    sample   = 1'b0;
    in_ready = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !rst;
        if (in_valid) begin
          capture = 1'b1;
          state_n = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt == '0) begin
          sample  = 1'b1;
          state_n = HOLD;
        end
      end
      HOLD: begin
        in_ready = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            capture = 1'b1;
            state_n = SETTLE;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign out_valid = (state == HOLD);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      add_a    <= '0;
      add_b    <= '0;
      out_sum  <= '0;
      out_cout <= 1'b0;
      out_ovf  <= 1'b0;
      acc      <= '0;
    end else begin
      if (capture) begin
        add_a <= in_acc ? eff_acc : in_a;
        add_b <= in_b;
        cnt   <= CNT_INIT;
      end else if (state == SETTLE && cnt != '0) begin
        cnt <= cnt - 4'd1;
      end
      if (sample) begin
        out_sum  <= result;
        out_cout <= cout;
        out_ovf  <= ovf;
      end
      // A clear on the sample edge beats the result write.
      if (acc_clr)     acc <= '0;
      else if (sample) acc <= result;
    end
  end

endmodule

// File: tb/tb_pfa_issue_ctrl.sv
// Directed bench for pfa_issue_ctrl: vector table on a SETTLE_CYC=1 instance, hand sequences
// for backpressure/latency on a SETTLE_CYC=3 instance, and asynchronous reset behaviour.
module tb_pfa_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b;
  logic        in_acc, acc_clr;

  logic        iv1, ir1, ov1, or1, co1, of1, bz1;
  logic [31:0] aa1, ab1, as1, os1;
  logic        iv3, ir3, ov3, or3, co3, of3, bz3;
  logic [31:0] aa3, ab3, as3, os3;

  int unsigned pass_cnt = 0;
  int unsigned total    = 0;

  always #5 clk = ~clk;

  assign as1 = aa1 + ab1;
  assign as3 = aa3 + ab3;

  pfa_issue_ctrl #(.WIDTH(32), .SETTLE_CYC(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .in_a(a), .in_b(b),
    .in_acc(in_acc), .acc_clr(acc_clr), .add_a(aa1), .add_b(ab1), .add_sum(as1),
    .out_valid(ov1), .out_ready(or1), .out_sum(os1), .out_cout(co1), .out_ovf(of1), .busy(bz1)
  );

  pfa_issue_ctrl #(.WIDTH(32), .SETTLE_CYC(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(iv3), .in_ready(ir3), .in_a(a), .in_b(b),
    .in_acc(in_acc), .acc_clr(acc_clr), .add_a(aa3), .add_b(ab3), .add_sum(as3),
    .out_valid(ov3), .out_ready(or3), .out_sum(os3), .out_cout(co3), .out_ovf(of3), .busy(bz3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else pass_cnt++;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        use_acc;
    logic        clr;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

`ifdef PFA_SAT_EN
  localparam logic [31:0] POS_OVF = 32'h7FFF_FFFF;
  localparam logic [31:0] NEG_OVF = 32'h8000_0000;
`else
  localparam logic [31:0] POS_OVF = 32'h8000_0000;
  localparam logic [31:0] NEG_OVF = 32'h0000_0000;
`endif

  // One transaction on dut1: accept, settle, check result, drain.
  task automatic xact1(input string tag, input logic [31:0] va, input logic [31:0] vb,
                       input logic ua, input logic clr_accept, input logic clr_sample,
                       input logic [31:0] esum, input logic ecout, input logic eovf);
    @(negedge clk);
    a = va; b = vb; in_acc = ua; acc_clr = clr_accept; iv1 = 1'b1; or1 = 1'b0;
    #1 chk({tag, ".in_ready"}, 32'(ir1), 32'd1);
    @(posedge clk); #1;
    chk({tag, ".valid_early"}, 32'(ov1), 32'd0);
    @(negedge clk);
    iv1 = 1'b0; acc_clr = clr_sample; a = 32'hDEAD_BEEF; b = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    chk({tag, ".valid"}, 32'(ov1), 32'd1);
    chk({tag, ".sum"},   os1,         esum);
    chk({tag, ".cout"},  32'(co1),    32'(ecout));
    chk({tag, ".ovf"},   32'(of1),    32'(eovf));
    @(negedge clk);
    acc_clr = 1'b0; or1 = 1'b1;
    @(posedge clk); #1;
    chk({tag, ".drained"}, 32'(ov1), 32'd0);
    @(negedge clk);
    or1 = 1'b0;
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, POS_OVF,       1'b0, 1'b1};
    vecs[2] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, NEG_OVF,       1'b1, 1'b1};
    vecs[3] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0};
    vecs[4] = '{32'hDEAD_BEEF, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0005, 1'b0, 1'b0};
    vecs[5] = '{32'hDEAD_BEEF, 32'h0000_0007, 1'b1, 1'b0, 32'h0000_000C, 1'b0, 1'b0};
    vecs[6] = '{32'hDEAD_BEEF, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0003, 1'b0, 1'b0};
    vecs[7] = '{32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0};

    rst = 1'b1; a = '0; b = '0; in_acc = 1'b0; acc_clr = 1'b0;
    iv1 = 1'b0; or1 = 1'b0; iv3 = 1'b0; or3 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid", 32'(ov1), 32'd0);
    chk("rst.busy",  32'(bz1), 32'd0);
    chk("rst.sum",   os1,      32'd0);
    chk("rst.add_a", aa1,      32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rst.in_ready_after", 32'(ir1), 32'd1);

    for (int i = 0; i < 8; i++)
      xact1($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].use_acc, vecs[i].clr,
            1'b0, vecs[i].sum, vecs[i].cout, vecs[i].ovf);

    // acc is FFFFFFFF now; accumulate 1 wraps to 0 with carry.
    xact1("acc_wrap", 32'h0, 32'h1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    // Clear on the sample edge: result still reported, acc left at 0.
    xact1("clr_smp", 32'd100, 32'd23, 1'b0, 1'b0, 1'b1, 32'd123, 1'b0, 1'b0);
    xact1("acc_after_clr", 32'h0, 32'd4, 1'b1, 1'b0, 1'b0, 32'd4, 1'b0, 1'b0);

    // Backpressure and latency on the SETTLE_CYC=3 instance.
    @(negedge clk);
    a = 32'd1000; b = 32'd234; in_acc = 1'b0; iv3 = 1'b1; or3 = 1'b0;
    @(posedge clk); #1 chk("bp.valid_t0", 32'(ov3), 32'd0);
    @(negedge clk); iv3 = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bp.valid_t%0d", k), 32'(ov3), (k == 3) ? 32'd1 : 32'd0);
    end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("bp.hold_sum",   os3,      32'd1234);
      chk("bp.hold_valid", 32'(ov3), 32'd1);
      chk("bp.hold_rdy",   32'(ir3), 32'd0);
      chk("bp.hold_busy",  32'(bz3), 32'd1);
    end
    @(negedge clk);
    or3 = 1'b1; iv3 = 1'b1; a = 32'd5; b = 32'd6;
    #1 chk("b2b.in_ready", 32'(ir3), 32'd1);
    @(posedge clk); #1;
    chk("b2b.valid_t0", 32'(ov3), 32'd0);
    chk("b2b.busy",     32'(bz3), 32'd1);
    chk("b2b.add_a",    aa3,      32'd5);
    @(negedge clk); iv3 = 1'b0; or3 = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("b2b.valid_t%0d", k), 32'(ov3), (k == 3) ? 32'd1 : 32'd0);
    end
    chk("b2b.sum", os3, 32'd11);

    // Reset mid-HOLD: outputs drop before any clock edge.
    @(negedge clk); #2 rst = 1'b1;
    #1;
    chk("rsth.valid", 32'(ov3), 32'd0);
    chk("rsth.busy",  32'(bz3), 32'd0);
    chk("rsth.sum",   os3,      32'd0);
    chk("rsth.add_b", ab3,      32'd0);
    @(negedge clk); rst = 1'b0;

    // Reset mid-SETTLE.
    @(negedge clk);
    a = 32'd7; b = 32'd8; iv3 = 1'b1;
    @(posedge clk); #1 chk("rsts.busy_pre", 32'(bz3), 32'd1);
    iv3 = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rsts.busy",  32'(bz3), 32'd0);
    chk("rsts.valid", 32'(ov3), 32'd0);
    chk("rsts.add_a", aa3,      32'd0);
    @(negedge clk); rst = 1'b0;

    xact1("post_rst", 32'd10, 32'd20, 1'b0, 1'b0, 1'b0, 32'd30, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
